// File: rtl/pe_pkg.sv
// pe_pkg
//   Types and constants shared by the processing-element blocks: the
//   coefficient width, the default polynomial length and the state
//   encoding of the polynomial-add sequencer.
package pe_pkg;

  localparam int Q_W        = 23;
  localparam int N_COEF_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } add_state_t;

endpackage

// File: rtl/mod_add.sv
// mod_add
//   Combinational modular adder: sum = (a + b) mod q, assuming a, b < q.
//   Operands arrive one bit wider than q so callers can feed raw sums.
//   If an operand is out of range, the single conditional subtraction
//   leaves a value that may still be >= q. That value is truncated to
//   Q_W bits, and no error flag is raised.
// Ports
//   a, b : operands, Q_W+1 bits
//   q    : modulus, Q_W bits
//   sum  : result, Q_W bits
module mod_add
  import pe_pkg::*;
(
  input  logic [Q_W:0]   a,
  input  logic [Q_W:0]   b,
  input  logic [Q_W-1:0] q,
  output logic [Q_W-1:0] sum
);

  logic [Q_W+1:0] raw;
  logic [Q_W+1:0] q_ext;

  assign raw   = {1'b0, a} + {1'b0, b};
  assign q_ext = {2'b00, q};
  assign sum   = (raw >= q_ext) ? Q_W'(raw - q_ext) : raw[Q_W-1:0];

endmodule

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl
//   Streams two coefficient memories through one mod_add and writes back
//   (a+b) mod q, one coefficient per cycle, N_COEF coefficients per start.
//   Every output is registered.
//
//   Timing, counted from the cycle in which start is accepted (cycle 0):
//   - read of address k in cycle k+1
//   - write of address k in cycle k+3
//   - done_o pulses in cycle N_COEF+3
//
// Ports
//   clk_i, rst_n_i          : clock, async active-low reset
//   start_i                 : start request, only sampled in IDLE
//   q_i                     : modulus, captured on start
//   a_data_i, b_data_i      : memory read data, one cycle after rd_en_o
//   rd_en_o, rd_addr_o      : shared read strobe/address for A and B
//   wr_en_o, wr_addr_o,
//   wr_data_o               : result write port
//   busy_o, done_o          : status
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads 0..N_COEF-1, one per cycle
// DRAIN | no more reads; flushing the last two pipeline stages
// DONE  | one-cycle completion, done_o high
module poly_add_ctrl
  import pe_pkg::*;
#(
  parameter int N_COEF = N_COEF_DEF,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [Q_W-1:0]    q_i,
  input  logic [Q_W-1:0]    a_data_i,
  input  logic [Q_W-1:0]    b_data_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [Q_W-1:0]    wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);

  add_state_t        state;
  logic [Q_W-1:0]    q_r;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic [Q_W-1:0]    sum;

  mod_add u_mod_add (
    .a   ({1'b0, a_data_i}),
    .b   ({1'b0, b_data_i}),
    .q   (q_r),
    .sum (sum)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      q_r        <= '0;
      rd_en_o    <= 1'b0;
      rd_addr_o  <= '0;
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      // Stage 1 lines up with the memory data; stage 2 is the write port.
      pipe_valid <= rd_en_o;
      pipe_addr  <= rd_addr_o;
      wr_en_o    <= pipe_valid;
      wr_addr_o  <= pipe_addr;
      if (pipe_valid) begin
        wr_data_o <= sum;
      end
      done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= RUN;
            q_r       <= q_i;
            rd_en_o   <= 1'b1;
            rd_addr_o <= '0;
            busy_o    <= 1'b1;
          end
        end
        RUN: begin
          if (rd_addr_o == LAST_ADDR) begin
            rd_en_o <= 1'b0;
            state   <= DRAIN;
          end else begin
            rd_addr_o <= rd_addr_o + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // The write on the port now is the last one: nothing is left in stage 1.
          if (wr_en_o && !pipe_valid) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_add_ctrl.sv
module tb_poly_add_ctrl;
  import pe_pkg::*;

  localparam int N  = 256;
  localparam int AW = 8;
  localparam logic [22:0] QBIG   = 23'd8380417;
  localparam logic [22:0] QSMALL = 23'd3329;

  logic          clk = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [22:0]   q_i = '0;
  logic [22:0]   a_data_i = '0;
  logic [22:0]   b_data_i = '0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [22:0]   wr_data_o;
  logic          busy_o;
  logic          done_o;

  poly_add_ctrl #(.N_COEF(N), .ADDR_W(AW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .q_i       (q_i),
    .a_data_i  (a_data_i),
    .b_data_i  (b_data_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  logic [22:0] q_model = '0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [22:0] a_mem [N];
  logic [22:0] b_mem [N];
  logic [22:0] res   [N];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [22:0]   data;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories, 1-cycle latency.
  always @(posedge clk) begin
    if (rd_en_o) begin
      a_data_i <= a_mem[rd_addr_o];
      b_data_i <= b_mem[rd_addr_o];
    end
  end

  // Scoreboard: reads push the expected result, writes pop and compare.
  always @(negedge clk) begin
    if (rst_n_i) begin
      if (rd_en_o) begin
        chk("rd_addr_seq", rd_addr_o, cyc - c0 - 1);
        mon_e.addr = rd_addr_o;
        mon_e.data = 23'((longint'(a_mem[rd_addr_o]) + longint'(b_mem[rd_addr_o]))
                         % longint'(q_model));
        sb.push_back(mon_e);
      end
      if (wr_en_o) begin
        wr_cnt++;
        chk("wr_cycle", cyc - c0, wr_addr_o + 3);
        if (sb.size() == 0) begin
          chk("sb_underflow", wr_en_o, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_addr", wr_addr_o, mon_e.addr);
          chk("wr_data", wr_data_o, mon_e.data);
          res[wr_addr_o] = wr_data_o;
        end
      end
      if (done_o) begin
        done_cnt++;
        chk("done_with_busy", busy_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [22:0] q, input bit hold);
    q_i     = q;
    q_model = q;
    start_i = 1'b1;
    c0      = cyc;
    tick();
    start_i = hold;
    chk("c1_busy", busy_o, 1);
    chk("c1_rd_en", rd_en_o, 1);
    chk("c1_rd_addr", rd_addr_o, 0);
    chk("c1_done", done_o, 0);
  endtask

  task automatic run_wait(input bit hold, input int p1, input int p2, input int qchg,
                          output int done_rel);
    int rel;
    done_rel = -1;
    for (int i = 0; i < N + 20; i++) begin
      tick();
      rel = cyc - c0;
      start_i = (rel == p1 || rel == p2) ? 1'b1 : hold;
      if (rel == qchg) q_i = QSMALL;
      if (done_o) begin
        done_rel = rel;
        break;
      end
      chk("busy_window", busy_o, (rel <= N + 2));
      chk("rd_en_window", rd_en_o, (rel <= N));
    end
    chk("done_cycle", done_rel, N + 3);
  endtask

  task automatic fill_seq();
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 23'(k);
      b_mem[k] = 23'(2 * k);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      a_mem[k] = 23'($urandom_range(32'(QBIG) - 1, 0));
      b_mem[k] = 23'($urandom_range(32'(QBIG) - 1, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dr, dr2, w0, d0, d1abs;

    fill_seq();
    rst_n_i = 1'b0;
    repeat (2) tick();
    chk("reset_outputs",
        {rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o}, 0);
    rst_n_i = 1'b1;
    tick();
    chk("idle_busy", busy_o, 0);

    // Sequential sum
    w0 = wr_cnt; d0 = done_cnt;
    start_op(QBIG, 1'b0);
    run_wait(1'b0, -1, -1, -1, dr);
    tick();
    chk("seq_writes", wr_cnt - w0, N);
    chk("seq_dones", done_cnt - d0, 1);
    chk("seq_sb_empty", sb.size(), 0);
    chk("seq_res0", res[0], 0);
    chk("seq_res100", res[100], 300);
    chk("seq_res255", res[255], 765);
    chk("seq_done_low", done_o, 0);
    chk("seq_idle_busy", busy_o, 0);

    // Modular wrap corners plus random in-range data
    fill_rand();
    a_mem[0] = QBIG - 1; b_mem[0] = 23'd1;
    a_mem[1] = QBIG - 1; b_mem[1] = QBIG - 1;
    a_mem[2] = 23'd0;    b_mem[2] = 23'd0;
    w0 = wr_cnt;
    start_op(QBIG, 1'b0);
    run_wait(1'b0, -1, -1, -1, dr);
    tick();
    chk("wrap_res0", res[0], 0);
    chk("wrap_res1", res[1], 8380415);
    chk("wrap_res2", res[2], 0);
    chk("wrap_writes", wr_cnt - w0, N);

    // Start pulses while busy are ignored and not queued
    fill_seq();
    w0 = wr_cnt; d0 = done_cnt;
    start_op(QBIG, 1'b0);
    run_wait(1'b0, 5, 258, -1, dr);
    tick();
    chk("busy_start_writes", wr_cnt - w0, N);
    chk("busy_start_dones", done_cnt - d0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_restart_busy", busy_o, 0);
      chk("no_restart_rd_en", rd_en_o, 0);
    end

    // q_i change mid-operation has no effect
    fill_rand();
    w0 = wr_cnt;
    start_op(QBIG, 1'b0);
    run_wait(1'b0, -1, -1, 10, dr);
    tick();
    chk("qchg_writes", wr_cnt - w0, N);
    chk("qchg_sb_empty", sb.size(), 0);
    q_i = QBIG;

    // Asynchronous reset in cycle 100
    fill_seq();
    start_op(QBIG, 1'b0);
    repeat (99) tick();
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_reset_outputs",
        {rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o}, 0);
    sb.delete();
    w0 = wr_cnt; d0 = done_cnt;
    repeat (3) tick();
    chk("reset_hold_outputs",
        {rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o}, 0);
    chk("reset_no_writes", wr_cnt - w0, 0);
    chk("reset_no_done", done_cnt - d0, 0);
    #1;
    rst_n_i = 1'b1;
    tick();
    w0 = wr_cnt;
    start_op(QBIG, 1'b0);
    run_wait(1'b0, -1, -1, -1, dr);
    tick();
    chk("after_reset_writes", wr_cnt - w0, N);
    chk("after_reset_dones", done_cnt - d0, 1);
    chk("after_reset_res255", res[255], 765);

    // Back-to-back with start_i held high
    w0 = wr_cnt; d0 = done_cnt;
    start_op(QBIG, 1'b1);
    run_wait(1'b1, -1, -1, -1, dr);
    d1abs = c0 + dr;
    c0 = c0 + N + 4;
    tick();
    chk("b2b_gap_busy", busy_o, 0);
    tick();
    chk("b2b_rd_addr", rd_addr_o, 0);
    chk("b2b_rd_en", rd_en_o, 1);
    chk("b2b_busy", busy_o, 1);
    start_i = 1'b0;
    run_wait(1'b0, -1, -1, -1, dr2);
    chk("b2b_done_spacing", (c0 + dr2) - d1abs, N + 4);
    tick();
    chk("b2b_writes", wr_cnt - w0, 2 * N);
    chk("b2b_dones", done_cnt - d0, 2);
    chk("b2b_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_add_ctrl.md
# poly_add_ctrl

Sequencer that performs coefficient-wise polynomial addition mod q by streaming two coefficient memories through one `mod_add` instance and writing the result back. One `start_i` pulse processes `N_COEF` coefficients at one coefficient per cycle. Completion is signalled by a one-cycle `done_o`. It sits in the PE between the coefficient RAMs and the modular arithmetic datapath.

## Interface
- `N_COEF`, default 256: coefficients per polynomial.
- `ADDR_W`, default 8: address width. Must satisfy 2^ADDR_W ≥ N_COEF.
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request. Sampled only in IDLE.
- `q_i` in 23: modulus. Captured into an internal register on an accepted start.
- `a_data_i` in 23: coefficient of A. Valid the cycle after the matching `rd_en_o`.
- `b_data_i` in 23: coefficient of B. Same timing as `a_data_i`.
- `rd_en_o` out 1: read strobe to both memories.
- `rd_addr_o` out ADDR_W: read address, shared by A and B.
- `wr_en_o` out 1: result write strobe.
- `wr_addr_o` out ADDR_W: result address.
- `wr_data_o` out 23: result coefficient, (a+b) mod q.
- `busy_o` out 1: operation in progress.
- `done_o` out 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: start_i=1 → RUN; start_i=0 → IDLE.
  - RUN: after issuing read address N_COEF-1 → DRAIN; otherwise RUN.
  - DRAIN: when the last write has been issued → DONE.
  - DONE: → IDLE unconditionally.
- On an accepted start, `q_r` ← `q_i`. `q_r` is held for the whole operation, so later changes on `q_i` have no effect.
- RUN: `rd_en_o`=1, and `rd_addr_o` counts 0..N_COEF-1, incrementing by 1 per cycle with no gaps. The counter does not wrap within one operation.
- Datapath: `mod_add` gets a={1'b0,a_data_i}, b={1'b0,b_data_i}, q=`q_r`. Its 23-bit output is registered into `wr_data_o`.
- The read address is delayed through a 2-stage pipeline to form `wr_addr_o`. A 2-stage valid pipeline forms `wr_en_o`.
- Inputs must satisfy a,b < q. The block does not check this. Out-of-range inputs give the truncated `mod_add` result, with no error flag.
- `start_i` is ignored in RUN, DRAIN and DONE. It is neither queued nor latched.
- Reset, including mid-operation: state → IDLE, counters and pipeline cleared, in-flight writes dropped. No `done_o` is produced.

## Timing
- Reset values: every output 0, including `rd_addr_o`, `wr_addr_o` and `wr_data_o`. `q_r` resets to 0.
- All outputs are registered; none is combinational from any input.
- Cycle numbering: cycle 0 is the cycle in which `start_i`=1 is sampled in IDLE.
- Cycle 1: `busy_o`=1, `rd_en_o`=1, `rd_addr_o`=0.
- Cycle k+1: read of address k. Cycle k+2: memory data present. Cycle k+3: `wr_en_o`=1, `wr_addr_o`=k.
  - Read-to-write latency is 2 cycles.
- Last read in cycle N_COEF. Last write in cycle N_COEF+2.
- Cycle N_COEF+3: `done_o`=1 and `busy_o`=0.
- The earliest next accepted start is sampled in cycle N_COEF+4.
- `busy_o` is 1 exactly in cycles 1..N_COEF+2. `done_o` is never high together with `busy_o`.
- Memories are synchronous-read with 1-cycle latency. There is no back-pressure; writes are always accepted.

## Structure
- Shared package `pe_pkg`:
  - `Q_W`=23.
  - `N_COEF_DEF`=256.
  - enum `add_state_t` {IDLE, RUN, DRAIN, DONE}.
- One sub-module: the existing `mod_add`, instantiated once. The controller contains no second adder.
- Internal content: one FSM, one read counter, a 2-deep pipeline of {valid, addr}, and the `q_r` and `wr_data_o` registers.

## Test plan
- Sequential sum: q=8380417, a[k]=k, b[k]=2k, N_COEF=256.
  - → 256 writes, `wr_addr_o`=k, `wr_data_o`=3k, in consecutive cycles 3..258.
  - → `done_o` in cycle 259 only.
- Modular wrap: q=8380417.
  - a=8380416, b=1 → 0.
  - a=b=8380416 → 8380415.
  - a=b=0 → 0.
- Start while busy: pulse `start_i` in cycles 5 and 258.
  - → no restart, address sequence unchanged, exactly one `done_o`.
- q change during operation: `q_i` switches from 8380417 to 3329 at cycle 10.
  - → all results still reduced mod 8380417.
- Reset mid-operation: `rst_n_i` low asynchronously in cycle 100.
  - → all outputs 0 immediately, no further writes, no `done_o`.
  - → after release, a new start runs the full sequence from address 0.
- Back-to-back: `start_i` held high continuously.
  - → second operation starts with `rd_addr_o`=0 in cycle N_COEF+5.
  - → `done_o` pulses are N_COEF+4 cycles apart.
